// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit_pkg
// Brief  : Shared RV32M mul/div constants, state encoding and operand helpers
// Rev    : 1.0
// ============================================================================
package ex_muldiv_unit_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic md_a_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit_if
// Brief  : EX-stage mul/div request/response bundle (pipeline <-> unit)
// Rev    : 1.0
// ============================================================================
interface ex_muldiv_unit_if
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, a, b,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, kill, funct3, a, b,
        output stall, busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_fixup.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit_fixup
// Brief  : Sign correction and special-case selection of the final result
// Rev    : 1.0
// ============================================================================
module ex_muldiv_unit_fixup
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic [2:0]        i_funct3,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic              i_neg_q,
    input  logic              i_neg_r,
    input  logic              i_div0,
    input  logic              i_ovf,
    input  logic [XLEN-1:0]   i_a,
    output logic [XLEN-1:0]   o_result
);
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // Divide layout: remainder in the upper half, quotient in the lower half.
    assign w_prod = i_neg_q ? -i_acc : i_acc;
    assign w_quo  = i_neg_q ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
    assign w_rem  = i_neg_r ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];

    always_comb begin
        o_result = '0;
        unique case (i_funct3)
            MD_MUL:                       o_result = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU: begin
                if (i_div0)     o_result = '1;
                else if (i_ovf) o_result = i_a;
                else            o_result = w_quo;
            end
            MD_REM, MD_REMU: begin
                if (i_div0)     o_result = i_a;
                else if (i_ovf) o_result = '0;
                else            o_result = w_rem;
            end
            default:            o_result = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit
// Brief  : Iterative RV32M multiply/divide unit for the EX stage
// Rev    : 1.0
// ============================================================================
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic             clock,
    input  logic             reset,
    ex_muldiv_unit_if.slave  io_md
);
    localparam int                CNT_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_count;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_result;
    logic [2:0]         r_funct3;
    logic               r_sa;
    logic               r_sb;
    logic               r_done;
    logic               r_busy;

    logic               w_idle;
    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN:0]      w_mul_sum;
    logic [2*XLEN-1:0]  w_mul_next;
    logic [2*XLEN:0]    w_div_shift;
    logic [XLEN:0]      w_div_hi;
    logic               w_div_ge;
    logic [XLEN-1:0]    w_div_diff;
    logic [2*XLEN-1:0]  w_div_next;
    logic [2*XLEN-1:0]  w_step;
    logic [2:0]         w_fx_funct3;
    logic               w_fx_neg_q;
    logic               w_fx_neg_r;
    logic [XLEN-1:0]    w_fx_result;

    // Operand decode on the live ID/EX values; only used in the accepting cycle.
    assign w_idle  = (r_state == ST_IDLE);
    assign w_sa    = md_a_signed(io_md.funct3) & io_md.a[XLEN-1];
    assign w_sb    = md_b_signed(io_md.funct3) & io_md.b[XLEN-1];
    assign w_mag_a = w_sa ? -io_md.a : io_md.a;
    assign w_mag_b = w_sb ? -io_md.b : io_md.b;
    assign w_div0  = io_md.funct3[2] & (io_md.b == '0);
    assign w_ovf   = io_md.funct3[2] & ~io_md.funct3[0] & (io_md.a == C_MIN) & (io_md.b == '1);

    // Shift-add: multiplier drains out of the low half as the product builds.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: partial remainder can briefly need XLEN+1 bits.
    assign w_div_shift = {r_acc, 1'b0};
    assign w_div_hi    = w_div_shift[2*XLEN:XLEN];
    assign w_div_ge    = (w_div_hi >= {1'b0, r_b});
    assign w_div_diff  = w_div_hi[XLEN-1:0] - r_b;
    assign w_div_next  = w_div_ge ? {w_div_diff, w_div_shift[XLEN-1:1], 1'b1}
                                  : w_div_shift[2*XLEN-1:0];

    assign w_step = r_funct3[2] ? w_div_next : w_mul_next;

    assign w_fx_funct3 = w_idle ? io_md.funct3 : r_funct3;
    assign w_fx_neg_q  = w_idle ? (w_sa ^ w_sb) : (r_sa ^ r_sb);
    assign w_fx_neg_r  = w_idle ? w_sa : r_sa;

    ex_muldiv_unit_fixup #(
        .XLEN (XLEN)
    ) u_fixup (
        .i_funct3 (w_fx_funct3),
        .i_acc    (w_step),
        .i_neg_q  (w_fx_neg_q),
        .i_neg_r  (w_fx_neg_r),
        .i_div0   (w_idle & w_div0),
        .i_ovf    (w_idle & w_ovf),
        .i_a      (io_md.a),
        .o_result (w_fx_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_funct3 <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (io_md.kill) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (io_md.start) begin
                            r_funct3 <= io_md.funct3;
                            r_sa     <= w_sa;
                            r_sb     <= w_sb;
                            r_b      <= w_mag_b;
                            r_acc    <= {{XLEN{1'b0}}, w_mag_a};
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            if (w_div0 | w_ovf) begin
                                r_result <= w_fx_result;
                                r_done   <= 1'b1;
                                r_state  <= ST_DONE;
                            end else begin
                                r_state  <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        r_acc   <= w_step;
                        r_count <= r_count + 1'b1;
                        if (r_count == C_LAST) begin
                            r_result <= w_fx_result;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Reset gates stall so a held start cannot freeze the pipeline during reset.
    assign io_md.stall  = io_md.start & ~r_done & ~io_md.kill & ~reset;
    assign io_md.busy   = r_busy;
    assign io_md.done   = r_done;
    assign io_md.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_muldiv_unit
// Brief  : Scoreboard bench for ex_muldiv_unit with directed RV32M vectors
// Rev    : 1.0
// ============================================================================
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic clock;
    logic reset;

    ex_muldiv_unit_if #(.XLEN(32)) md ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .io_md (md)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;
    logic [31:0] mon_exp;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (md.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result 0x%08h, expected no done", md.result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", md.result, mon_exp);
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] ra, input logic [31:0] rb,
                          input logic [31:0] exp, input int lat, input bit midchg, input bit hold);
        int c;
        bit got;
        @(posedge clock); #1;
        md.start  = 1'b1;
        md.funct3 = f3;
        md.a      = ra;
        md.b      = rb;
        exp_q.push_back(exp);
        last_exp = exp;
        c   = 0;
        got = 1'b0;
        while (!got && c <= 40) begin
            @(negedge clock);
            if (md.done === 1'b1) begin
                got = 1'b1;
                check("latency", 32'(c), 32'(lat));
                check("stall_in_done", 32'(md.stall), 32'd0);
            end else begin
                check("stall_while_busy", 32'(md.stall), 32'd1);
                if (midchg && c == 5) begin
                    md.a      = 32'h1234_5678;
                    md.b      = 32'h0000_0000;
                    md.funct3 = MD_MUL;
                end
                c++;
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        if (!hold) begin
            @(posedge clock); #1;
            md.start = 1'b0;
            @(negedge clock);
            check("busy_after_done", 32'(md.busy), 32'd0);
            check("done_single_pulse", 32'(md.done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        md.start  = 1'b0;
        md.kill   = 1'b0;
        md.funct3 = 3'b000;
        md.a      = '0;
        md.b      = '0;
        #3;
        check("reset_result", md.result, 32'd0);
        check("reset_busy",   32'(md.busy),  32'd0);
        check("reset_done",   32'(md.done),  32'd0);
        check("reset_stall",  32'(md.stall), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Multiplies
        run_op(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, 1'b0);
        run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0, 1'b0);
        run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 1'b0);
        run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);

        // Divides, including operand corruption mid-calculation
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, 1'b0);
        run_op(MD_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
        run_op(MD_DIVU, 32'd100,       32'd7, 32'd14,        33, 1'b1, 1'b0);
        run_op(MD_REMU, 32'd100,       32'd7, 32'd2,         33, 1'b1, 1'b0);

        // Special cases complete in one cycle
        run_op(MD_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        run_op(MD_REM, 32'd5,         32'd0,         32'd5,         1, 1'b0, 1'b0);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b0);
        run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b0, 1'b0);

        // Back-to-back with start held through done
        run_op(MD_DIVU, 32'd100, 32'd7,         32'd14,        33, 1'b0, 1'b1);
        run_op(MD_MUL,  32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, 1'b0);

        // Kill at cycle 10 of a DIV
        @(posedge clock); #1;
        md.start  = 1'b1;
        md.funct3 = MD_DIV;
        md.a      = 32'd100;
        md.b      = 32'd7;
        repeat (10) @(posedge clock);
        #1 md.kill = 1'b1;
        #1;
        check("stall_on_kill", 32'(md.stall), 32'd0);
        check("busy_before_kill_edge", 32'(md.busy), 32'd1);
        @(posedge clock); #1;
        md.kill  = 1'b0;
        md.start = 1'b0;
        @(negedge clock);
        check("busy_after_kill", 32'(md.busy), 32'd0);
        check("result_kept_after_kill", md.result, last_exp);
        repeat (40) @(negedge clock);
        check("result_still_kept", md.result, last_exp);

        // Asynchronous reset at cycle 5 of a MUL, checked before any clock edge
        @(posedge clock); #1;
        md.start  = 1'b1;
        md.funct3 = MD_MUL;
        md.a      = 32'd7;
        md.b      = 32'hFFFF_FFFD;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst_result", md.result, 32'd0);
        check("async_rst_busy",   32'(md.busy),  32'd0);
        check("async_rst_done",   32'(md.done),  32'd0);
        check("async_rst_stall",  32'(md.stall), 32'd0);
        @(posedge clock); #1;
        md.start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("idle_after_reset", 32'(md.busy), 32'd0);

        // Recovery after reset
        run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Takes ID/EX operands RD1E/RD2E and funct3, then computes over multiple cycles.
- Raises stall so the hazard logic holds IF, ID and ID/EX. Ends with a one-cycle done pulse, with the result muxed into ALUResultE.

Parameters:
- XLEN, 32, operand/result width; CNT_W derived as clog2(XLEN).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  EX holds a valid M-extension op (MulDivE from ID/EX)
- kill  in  1  abort current op (trap/pipeline flush of EX)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- stall  out  1  hold upstream stages; OR'd into ID/EX enable deassert
- busy  out  1  state != IDLE
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  registered result, held until next done

Behaviour:
- Reset (async) values: state=IDLE, count=0, result=0, done=0, busy=0, stall=0, internal accumulators=0.
- States: IDLE, CALC, DONE.
- IDLE, start=1 and kill=0:
  - Latch funct3, operand signs and operand magnitudes (signed per op: MULH both, MULHSU a only, DIV/REM both).
  - Divide by zero or signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) → DONE next cycle.
  - Otherwise → CALC with count=0.
- CALC:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on the latched magnitudes; 2*XLEN-bit product/remainder register.
  - count increments; at count=XLEN-1 → DONE.
  - a, b and funct3 changes during CALC are ignored.
- DONE:
  - result register loaded on entry.
  - done=1 for exactly this cycle → IDLE.
- Latency: normal op done in cycle XLEN+1 after acceptance (33 for XLEN=32); special cases done in cycle 1.
- stall = start & ~done & ~kill, combinational. Stall is high from the accepting cycle through the last CALC cycle and low in DONE, so ID/EX advances when done is high.
- Requirement on surrounding pipeline: this unit is the only EX-stage stall source. ID/EX therefore always advances on done, and the op is never re-accepted.
- A start seen in IDLE in the cycle after DONE is a new instruction and is accepted.
- Result fix-up (applied when loading result):
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word, negated 2*XLEN product if sign(a) xor sign(b) as applicable.
  - DIV/DIVU: quotient, negated if signs differ (DIV only).
  - REM/REMU: remainder, sign of dividend (REM only).
- Special results:
  - div-by-zero: quotient=all ones, remainder=a.
  - overflow: quotient=0x80000000, remainder=0.
- kill has priority over every transition: any state → IDLE next cycle, no done, result unchanged, stall=0 immediately.
- start=0 in IDLE: stay idle, outputs hold.
- Reset mid-CALC: all state and outputs clear asynchronously; no done.

Decomposition:
- Shared package holds:
  - funct3 constants MD_MUL…MD_REMU
  - state encoding typedef (IDLE/CALC/DONE)
  - XLEN constant shared with the ID/EX register
- Single module. An optional sub-module ex_muldiv_fixup (combinational sign correction/special-case result select) keeps the FSM file small.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → stall high cycles 0–32, done at cycle 33, result=0xFFFFFFEB, busy low cycle 34.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; operands changed mid-CALC do not affect results.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, done at cycle 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, done at cycle 1.
- Back-to-back: DIVU then MUL with start held high → second op accepted in the cycle after done; two distinct done pulses with correct results, no duplicate.
- kill asserted at cycle 10 of a DIV → IDLE next cycle, stall low same cycle, no done, prior result retained. Async reset at cycle 5 → all outputs 0 without a clock edge.
